// File: rtl/turfio_align_pkg.sv
// Shared types and helpers for the CIN link-training sequencer.
//   state_t   : sequencer FSM states
//   ERR_*     : err_code_o encodings
//   rot_match : 1 when a nibble equals any rotation of the training pattern
package turfio_align_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_WAIT_ACK, S_NEXT,
      S_CENTER, S_SLIP_CAP, S_SLIP_WAIT, S_SLIP, S_DONE, S_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_EYE     = 2'd1;
   localparam logic [1:0] ERR_SLIP    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // During the eye scan the word boundary is still arbitrary, so any
   // rotation of the training nibble counts as a clean sample.
   function automatic logic rot_match(input logic [3:0] d, input logic [3:0] p);
      return (d == p) || (d == {p[2:0], p[3]}) ||
             (d == {p[1:0], p[3:2]}) || (d == {p[0], p[3:1]});
   endfunction

endpackage

// File: rtl/turfio_eye_tracker.sv
// Tracks runs of passing scan points and keeps the widest one.
//   clear      : forget everything (start of a new scan)
//   push/pass  : record one scan point at tap
//   finish     : fold the open run into the best result
//   best_start : first tap of widest run
//   best_width : width of widest run in taps
// Outputs already account for a still-open run, so the value seen in the
// same cycle as finish is the final one.
module turfio_eye_tracker
   import turfio_align_pkg::*;
#(
   parameter int DELAY_STEP = 8
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic       clear,
   input  logic       push,
   input  logic       pass,
   input  logic       finish,
   input  logic [8:0] tap,
   output logic [8:0] best_start,
   output logic [9:0] best_width
);

   logic [8:0] run_start, bst_start;
   logic [9:0] run_width, bst_width;
   logic       run_wins;

   // Strictly wider only: on a tie the earlier (lower tap) eye is kept.
   assign run_wins   = run_width > bst_width;
   assign best_start = run_wins ? run_start : bst_start;
   assign best_width = run_wins ? run_width : bst_width;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         run_start <= '0;
         run_width <= '0;
         bst_start <= '0;
         bst_width <= '0;
      end else if (clear) begin
         run_start <= '0;
         run_width <= '0;
         bst_start <= '0;
         bst_width <= '0;
      end else if (push && pass) begin
         if (run_width == '0) run_start <= tap;
         run_width <= run_width + 10'(DELAY_STEP);
      end else if (push || finish) begin
         if (run_wins) begin
            bst_start <= run_start;
            bst_width <= run_width;
         end
         run_width <= '0;
      end
   end

endmodule

// File: rtl/turfio_cin_align_ctrl.sv
// Automatic CIN link training: scans IDELAY taps, finds the widest passing
// eye, centres the delay, then bitslips until the training nibble aligns.
// Ports:
//   wb_clk_i, wb_rst_n_i        : clock, async active-low reset
//   start_i                     : one-cycle start (ignored while busy)
//   busy_o, done_o, err_o       : status; done/err held until next start
//   err_code_o                  : ERR_NONE/ERR_EYE/ERR_SLIP/ERR_TIMEOUT
//   en_vtc_o                    : IDELAY VTC enable (low while training)
//   delay_load_o, delay_cntvaluein_o : IDELAY load strobe and tap
//   capture_req_o, capture_ack_i, capture_data_i : capture handshake
//   bitslip_o                   : one-cycle bitslip strobe
//   eye_start_o, eye_width_o    : best eye geometry
//   scan_map_o                  : per-scan-point pass map, only when
//                                 TURFIO_ALIGN_SCAN_LOG_EN is defined
module turfio_cin_align_ctrl
   import turfio_align_pkg::*;
#(
   parameter logic [3:0] TRAIN_PATTERN = 4'h8,
   parameter int DELAY_STEP    = 8,
   parameter int MAX_TAP       = 511,
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_SAMPLES   = 4,
   parameter int MIN_EYE       = 32,
   parameter int ACK_TIMEOUT   = 1024
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [1:0] err_code_o,
   output logic       en_vtc_o,
   output logic       delay_load_o,
   output logic [8:0] delay_cntvaluein_o,
   output logic       capture_req_o,
   input  logic       capture_ack_i,
   input  logic [3:0] capture_data_i,
   output logic       bitslip_o,
   output logic [8:0] eye_start_o,
   output logic [9:0] eye_width_o
`ifdef TURFIO_ALIGN_SCAN_LOG_EN
   ,output logic [63:0] scan_map_o
`endif
);

   localparam int STEP_SH = $clog2(DELAY_STEP);

   state_t     state_q, state_d;
   logic [8:0] tap_q;
   logic [15:0] settle_cnt, to_cnt;
   logic [7:0] good_cnt;
   logic [2:0] slip_cnt;
   logic       pass_q, slip_phase_q;

   logic       start_ok, ack_good, settle_end, to_end, last_pt, eye_ok;
   logic [9:0] tap_nxt, ctr;
   logic [8:0] ctr_clamped, trk_start;
   logic [9:0] trk_width;

   assign start_ok   = start_i && (state_q inside {S_IDLE, S_DONE, S_ERR});
   assign ack_good   = rot_match(capture_data_i, TRAIN_PATTERN);
   assign settle_end = settle_cnt == 16'(SETTLE_CYCLES - 1);
   assign to_end     = to_cnt == 16'(ACK_TIMEOUT - 1);
   // 10-bit sum so the last scan point never wraps back to tap 0.
   assign tap_nxt    = {1'b0, tap_q} + 10'(DELAY_STEP);
   assign last_pt    = tap_nxt > 10'(MAX_TAP);
   assign eye_ok     = trk_width >= 10'(MIN_EYE);
   assign ctr        = {1'b0, trk_start} + {1'b0, trk_width[9:1]};
   assign ctr_clamped = (ctr > 10'(MAX_TAP)) ? 9'(MAX_TAP) : ctr[8:0];

   turfio_eye_tracker #(.DELAY_STEP(DELAY_STEP)) u_trk (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .clear      (start_ok),
      .push       (state_q == S_NEXT),
      .pass       (pass_q),
      .finish     (state_q == S_CENTER),
      .tap        (tap_q),
      .best_start (trk_start),
      .best_width (trk_width)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      busy_o        = 1'b1;
      done_o        = 1'b0;
      err_o         = 1'b0;
      en_vtc_o      = 1'b0;
      delay_load_o  = 1'b0;
      capture_req_o = 1'b0;
      bitslip_o     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            busy_o   = 1'b0;
            en_vtc_o = 1'b1;
            done_o   = state_q == S_DONE;
            err_o    = state_q == S_ERR;
            if (start_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            delay_load_o = 1'b1;
            state_d      = S_SETTLE;
         end
         S_SETTLE:
            if (settle_end) state_d = slip_phase_q ? S_SLIP_CAP : S_CAPTURE;
         S_CAPTURE: begin
            capture_req_o = 1'b1;
            state_d       = S_WAIT_ACK;
         end
         S_WAIT_ACK:
            if (capture_ack_i) begin
               if (!ack_good || good_cnt == 8'(NUM_SAMPLES - 1)) state_d = S_NEXT;
               else                                              state_d = S_CAPTURE;
            end else if (to_end) state_d = S_ERR;
         S_NEXT:
            state_d = last_pt ? S_CENTER : S_LOAD;
         S_CENTER:
            state_d = eye_ok ? S_LOAD : S_ERR;
         S_SLIP_CAP: begin
            capture_req_o = 1'b1;
            state_d       = S_SLIP_WAIT;
         end
         S_SLIP_WAIT:
            if (capture_ack_i) begin
               if (capture_data_i == TRAIN_PATTERN) state_d = S_DONE;
               else if (slip_cnt == 3'd4)           state_d = S_ERR;
               else                                 state_d = S_SLIP;
            end else if (to_end) state_d = S_ERR;
         S_SLIP: begin
            bitslip_o = 1'b1;
            state_d   = S_SETTLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         tap_q        <= '0;
         settle_cnt   <= '0;
         to_cnt       <= '0;
         good_cnt     <= '0;
         slip_cnt     <= '0;
         pass_q       <= 1'b0;
         slip_phase_q <= 1'b0;
         err_code_o   <= ERR_NONE;
         eye_start_o  <= '0;
         eye_width_o  <= '0;
      end else begin
         settle_cnt <= (state_q == S_SETTLE) ? settle_cnt + 16'd1 : '0;
         // Restarts from zero on every entry into a wait state.
         to_cnt <= (state_q inside {S_WAIT_ACK, S_SLIP_WAIT}) ? to_cnt + 16'd1 : '0;
         case (state_q)
            S_IDLE, S_DONE, S_ERR:
               if (start_i) begin
                  tap_q        <= '0;
                  good_cnt     <= '0;
                  slip_cnt     <= '0;
                  slip_phase_q <= 1'b0;
                  err_code_o   <= ERR_NONE;
                  eye_start_o  <= '0;
                  eye_width_o  <= '0;
               end
            S_WAIT_ACK:
               if (capture_ack_i) begin
                  if (!ack_good) begin
                     pass_q   <= 1'b0;
                     good_cnt <= '0;
                  end else if (good_cnt == 8'(NUM_SAMPLES - 1)) begin
                     pass_q   <= 1'b1;
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_cnt + 8'd1;
                  end
               end else if (to_end) err_code_o <= ERR_TIMEOUT;
            S_NEXT:
               if (!last_pt) tap_q <= tap_nxt[8:0];
            S_CENTER: begin
               eye_start_o <= trk_start;
               eye_width_o <= trk_width;
               if (!eye_ok) err_code_o <= ERR_EYE;
               else begin
                  tap_q        <= ctr_clamped;
                  slip_phase_q <= 1'b1;
               end
            end
            S_SLIP_WAIT:
               if (capture_ack_i) begin
                  if (capture_data_i != TRAIN_PATTERN && slip_cnt == 3'd4)
                     err_code_o <= ERR_SLIP;
               end else if (to_end) err_code_o <= ERR_TIMEOUT;
            S_SLIP:
               slip_cnt <= slip_cnt + 3'd1;
            default: ;
         endcase
      end
   end

   assign delay_cntvaluein_o = tap_q;

`ifdef TURFIO_ALIGN_SCAN_LOG_EN
   logic [63:0] scan_map_q;
   logic [5:0]  pt_idx;

   assign pt_idx = 6'(tap_q >> STEP_SH);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)                                  scan_map_q <= '0;
      else if (start_ok)                                scan_map_q <= '0;
      else if (state_q == S_NEXT && pass_q)             scan_map_q[pt_idx] <= 1'b1;
   end

   assign scan_map_o = scan_map_q;
`endif

endmodule

// File: tb/tb_turfio_cin_align_ctrl.sv
// Directed bench for turfio_cin_align_ctrl. A capture model answers each
// request with the nibble seen at the loaded tap: inside the configured
// eye(s) it returns 4'h4 rotated by the number of bitslips issued (if
// rotation is enabled), outside it returns 4'hF.
module tb_turfio_cin_align_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] cdata = 4'h0;
   logic       busy_o, done_o, err_o, en_vtc_o, delay_load_o, capture_req_o, bitslip_o;
   logic [1:0] err_code_o;
   logic [8:0] delay_cntvaluein_o, eye_start_o;
   logic [9:0] eye_width_o;
`ifdef TURFIO_ALIGN_SCAN_LOG_EN
   logic [63:0] scan_map_o;
`endif

   turfio_cin_align_ctrl dut (
      .wb_clk_i           (clk),
      .wb_rst_n_i         (rst_n),
      .start_i            (start),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .err_o              (err_o),
      .err_code_o         (err_code_o),
      .en_vtc_o           (en_vtc_o),
      .delay_load_o       (delay_load_o),
      .delay_cntvaluein_o (delay_cntvaluein_o),
      .capture_req_o      (capture_req_o),
      .capture_ack_i      (ack),
      .capture_data_i     (cdata),
      .bitslip_o          (bitslip_o),
      .eye_start_o        (eye_start_o),
      .eye_width_o        (eye_width_o)
`ifdef TURFIO_ALIGN_SCAN_LOG_EN
      ,.scan_map_o        (scan_map_o)
`endif
   );

   always #5 clk = ~clk;

   // model configuration (written by the main sequence only)
   int   lo1 = 1000, hi1 = -1, lo2 = 1000, hi2 = -1;
   logic rot_en = 1'b1;
   logic ack_en = 1'b1;
   int   slip_base = 0;

   // monitor state (written by the monitor only)
   int   cur_tap = 0;
   int   last_load = -1;
   int   slip_tot = 0;

   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] model_data(input int tap, input int slips);
      logic [3:0] r;
      if (!((tap >= lo1 && tap <= hi1) || (tap >= lo2 && tap <= hi2))) return 4'hF;
      r = 4'h4;
      if (rot_en) for (int i = 0; i < (slips % 4); i++) r = {r[2:0], r[3]};
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      if (delay_load_o) begin
         cur_tap   = int'(delay_cntvaluein_o);
         last_load = int'(delay_cntvaluein_o);
      end
      if (bitslip_o) slip_tot = slip_tot + 1;
   end

   // capture responder: ack one cycle after the request is seen
   initial begin
      logic pend;
      pend = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ack = 1'b0;
         if (pend) begin
            ack   = 1'b1;
            cdata = model_data(cur_tap, slip_tot - slip_base);
            pend  = 1'b0;
         end
         if (capture_req_o && ack_en) pend = 1'b1;
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done_o || err_o) && n < 20000) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 20000) chk({tag, "_bound"}, 64'd0, 64'd1);
   endtask

   task automatic run(input int l1, input int h1, input int l2, input int h2, input logic re);
      lo1 = l1; hi1 = h1; lo2 = l2; hi2 = h2; rot_en = re;
      slip_base = slip_tot;
      pulse_start();
   endtask

   initial begin
      int rec;
      // reset values
      #12;
      chk("rst_busy",  {63'd0, busy_o}, 64'd0);
      chk("rst_done",  {63'd0, done_o}, 64'd0);
      chk("rst_err",   {63'd0, err_o}, 64'd0);
      chk("rst_vtc",   {63'd0, en_vtc_o}, 64'd1);
      chk("rst_code",  64'(err_code_o), 64'd0);
      chk("rst_tap",   64'(delay_cntvaluein_o), 64'd0);
      chk("rst_strb",  {61'd0, delay_load_o, capture_req_o, bitslip_o}, 64'd0);
      chk("rst_eye",   {44'd0, eye_start_o, eye_width_o}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // single eye 96..199, one slip to align
      run(96, 199, 1000, -1, 1'b1);
      chk("t1_busy", {63'd0, busy_o}, 64'd1);
      chk("t1_vtc_lo", {63'd0, en_vtc_o}, 64'd0);
      wait_end("t1");
      chk("t1_done",  {63'd0, done_o}, 64'd1);
      chk("t1_err",   {63'd0, err_o}, 64'd0);
      chk("t1_start", 64'(eye_start_o), 64'd96);
      chk("t1_width", 64'(eye_width_o), 64'd104);
      chk("t1_load",  64'(last_load), 64'd148);
      chk("t1_slips", 64'(slip_tot - slip_base), 64'd1);
      chk("t1_vtc",   {63'd0, en_vtc_o}, 64'd1);
      chk("t1_busy0", {63'd0, busy_o}, 64'd0);
`ifdef TURFIO_ALIGN_SCAN_LOG_EN
      chk("t1_map", scan_map_o, 64'h0000_0000_01FF_F000);
`endif
      repeat (3) @(posedge clk);
      #1 chk("t1_hold", {63'd0, done_o}, 64'd1);

      // two equal eyes: lowest kept
      run(0, 31, 256, 287, 1'b1);
      wait_end("t2");
      chk("t2_done",  {63'd0, done_o}, 64'd1);
      chk("t2_start", 64'(eye_start_o), 64'd0);
      chk("t2_width", 64'(eye_width_o), 64'd32);
      chk("t2_load",  64'(last_load), 64'd16);

      // no passing taps
      run(1000, -1, 1000, -1, 1'b1);
      wait_end("t3");
      chk("t3_err",   {63'd0, err_o}, 64'd1);
      chk("t3_code",  64'(err_code_o), 64'd1);
      chk("t3_vtc",   {63'd0, en_vtc_o}, 64'd1);
      chk("t3_done",  {63'd0, done_o}, 64'd0);
      chk("t3_slips", 64'(slip_tot - slip_base), 64'd0);
      chk("t3_width", 64'(eye_width_o), 64'd0);

      // eye present, nibble never aligns
      run(96, 199, 1000, -1, 1'b0);
      wait_end("t4");
      chk("t4_err",   {63'd0, err_o}, 64'd1);
      chk("t4_code",  64'(err_code_o), 64'd2);
      chk("t4_slips", 64'(slip_tot - slip_base), 64'd4);
      chk("t4_start", 64'(eye_start_o), 64'd96);

      // start while busy ignored, then reset mid-scan
      run(96, 199, 1000, -1, 1'b1);
      repeat (300) @(posedge clk);
      #1 rec = int'(delay_cntvaluein_o);
      chk("t5_tap_moved", {63'd0, rec != 0}, 64'd1);
      pulse_start();
      #1;
      chk("t5_ign_busy", {63'd0, busy_o}, 64'd1);
      chk("t5_ign_tap",  {63'd0, int'(delay_cntvaluein_o) >= rec}, 64'd1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", {63'd0, busy_o}, 64'd0);
      chk("t5_rst_vtc",  {63'd0, en_vtc_o}, 64'd1);
      chk("t5_rst_tap",  64'(delay_cntvaluein_o), 64'd0);
      chk("t5_rst_stat", {60'd0, done_o, err_o, err_code_o}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("t5_idle", {63'd0, busy_o}, 64'd0);

      // capture ack withheld
      ack_en = 1'b0;
      run(96, 199, 1000, -1, 1'b1);
      repeat (500) @(posedge clk);
      #1 chk("t6_still_busy", {63'd0, busy_o}, 64'd1);
      wait_end("t6");
      chk("t6_err",  {63'd0, err_o}, 64'd1);
      chk("t6_code", 64'(err_code_o), 64'd3);
      chk("t6_vtc",  {63'd0, en_vtc_o}, 64'd1);
      ack_en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/turfio_cin_align_ctrl.md
Name: turfio_cin_align_ctrl

Overview:
- Automatic CIN link training sequencer in the wb_clk_i domain; replaces software-driven eye scan/bitslip.
- Drives the CIN IDELAY load/VTC controls, capture request and bitslip strobes of the TURFIO register/CIN path.
- Scans IDELAY taps, finds the widest passing eye, centres the delay, then bitslips until the training nibble aligns.
- Reports done/error and eye geometry to the register core.

Parameters:
- TRAIN_PATTERN, 4'h8, aligned training nibble expected on capture_data_i.
- DELAY_STEP, 8, tap increment per scan point (power of 2).
- MAX_TAP, 511, last tap scanned (inclusive).
- SETTLE_CYCLES, 16, wait after delay_load_o before first capture.
- NUM_SAMPLES, 4, consecutive good captures required for a tap to pass.
- MIN_EYE, 32, minimum eye width in taps; narrower is an error.
- ACK_TIMEOUT, 1024, cycles allowed for capture_ack_i per request.

Ports:
- wb_clk_i  in  1  control clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse
- busy_o  out  1  sequence in progress
- done_o  out  1  alignment complete, held until next start
- err_o  out  1  alignment failed, held until next start
- err_code_o  out  2  0 none, 1 eye too narrow, 2 no bitslip match, 3 capture timeout
- en_vtc_o  out  1  IDELAY VTC enable
- delay_load_o  out  1  one-cycle IDELAY load strobe
- delay_cntvaluein_o  out  9  tap value to load
- capture_req_o  out  1  one-cycle capture request
- capture_ack_i  in  1  one-cycle: capture_data_i valid (already synchronized)
- capture_data_i  in  4  captured CIN nibble
- bitslip_o  out  1  one-cycle bitslip strobe
- eye_start_o  out  9  first tap of best eye
- eye_width_o  out  10  best eye width in taps

Behaviour:
- Reset: busy/done/err/delay_load/capture_req/bitslip = 0; en_vtc_o = 1; err_code, cntvaluein, eye_* = 0; FSM IDLE. Reset mid-sequence aborts immediately with these values.
- States: IDLE, LOAD, SETTLE, CAPTURE, WAIT_ACK, NEXT, CENTER, SLIP_CAP, SLIP_WAIT, SLIP, DONE, ERR.
- IDLE/DONE/ERR + start_i: clear done/err/err_code/eye_*, en_vtc_o=0, tap=0, busy_o=1, -> LOAD. start_i while busy ignored.
- LOAD: delay_load_o=1 one cycle with cntvaluein=tap -> SETTLE; counts SETTLE_CYCLES then -> CAPTURE.
- CAPTURE: capture_req_o one cycle -> WAIT_ACK. Ack with data equal to any rotation of TRAIN_PATTERN is good; good count++; at NUM_SAMPLES -> NEXT(pass). Bad data -> NEXT(fail) immediately. Else -> CAPTURE.
- ACK_TIMEOUT cycles without ack in any wait -> ERR, code 3.
- NEXT: push pass/fail into tracker; if tap+DELAY_STEP > MAX_TAP (10-bit compare, no wrap) -> CENTER else tap += DELAY_STEP -> LOAD.
- Tracker: run of passes = start tap, width = passes*DELAY_STEP; best run replaced only if strictly wider (ties keep lowest tap); run open at scan end is evaluated.
- CENTER: latch eye_*; width < MIN_EYE -> ERR code 1; else tap = start + (width>>1), clamped to MAX_TAP; load, settle -> SLIP_CAP.
- SLIP_CAP/SLIP_WAIT: one capture; data == TRAIN_PATTERN -> DONE; else SLIP: bitslip_o one cycle, slip count++, wait SETTLE_CYCLES, recapture. 4 slips without match -> ERR code 2.
- DONE: en_vtc_o=1, busy_o=0, done_o=1. ERR: en_vtc_o=1, busy_o=0, err_o=1.
- Simultaneous ack and timeout terminal count: ack wins.

Optional Feature:
- Macro TURFIO_ALIGN_SCAN_LOG_EN. Defined: adds output scan_map_o [63:0], bit n = pass at scan point n (tap n*DELAY_STEP), cleared on start, valid when done_o or err_o. Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package turfio_align_pkg: FSM state enum, err_code localparams (ERR_NONE, ERR_EYE, ERR_SLIP, ERR_TIMEOUT), rotation-match function.
- Sub-module turfio_eye_tracker: clear/push(pass)/finish inputs, best start/width outputs.

Test Plan:
- Model passes taps 96..199 with pattern 4'h4 -> eye_start=96, eye_width=104, final load 148, one bitslip, done_o=1, en_vtc_o=1.
- Two eyes 0..31 and 256..287 (equal widths) -> eye_start=0 (tie keeps first), done.
- All taps fail -> err_o=1, err_code=1, en_vtc_o=1, no bitslip pulses.
- Eye present but data never equals 4'h8 in any slip -> exactly 4 bitslip pulses, err_code=2.
- Ack withheld 1024 cycles at first capture -> err_code=3; start_i mid-scan ignored; wb_rst_n_i low mid-scan -> all outputs to reset values next edge.
- TURFIO_ALIGN_SCAN_LOG_EN, eye 96..199 -> scan_map_o bits 12..24 set, all others 0.
